// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into AXI4-Lite
// transactions and returns one response each. Define AXI4LITE_CMD_MASTER_RANGE_CHECK_EN to reject cmd_addr >= ADDR_LIMIT locally.
module axi4lite_cmd_master #(
   parameter int          AW         = 12,
   parameter int unsigned ADDR_LIMIT = 'h20
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [31:0]   cmd_wdata,
   input  logic [3:0]    cmd_wstrb,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_write,
   output logic [31:0]   rsp_data,
   output logic [1:0]    rsp_resp,
   output logic [AW-1:0] m_awaddr,
   output logic          m_awvalid,
   input  logic          m_awready,
   output logic [31:0]   m_wdata,
   output logic [3:0]    m_wstrb,
   output logic          m_wvalid,
   input  logic          m_wready,
   input  logic [1:0]    m_bresp,
   input  logic          m_bvalid,
   output logic          m_bready,
   output logic [AW-1:0] m_araddr,
   output logic          m_arvalid,
   input  logic          m_arready,
   input  logic [31:0]   m_rdata,
   input  logic [1:0]    m_rresp,
   input  logic          m_rvalid,
   output logic          m_rready
);

   typedef enum logic [2:0] {
      IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP
   } state_t;

   state_t        state_q, state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          arvalid_q, arvalid_d;
   logic          bready_q, bready_d;
   logic          rready_q, rready_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_write_q, rsp_write_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic [1:0]    rsp_resp_q, rsp_resp_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;

   logic          aw_hs, w_hs, addr_illegal;
   logic          unused_bits;

   assign aw_hs = awvalid_q & m_awready;
   assign w_hs  = wvalid_q & m_wready;

`ifdef AXI4LITE_CMD_MASTER_RANGE_CHECK_EN
   assign addr_illegal = (32'(cmd_addr) >= ADDR_LIMIT);
`else
   assign addr_illegal = 1'b0;
`endif

   // Byte-lane bits of the address never reach the bus; the limit is dead in the default build.
   assign unused_bits = ^{cmd_addr[1:0], ADDR_LIMIT};

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_data_d  = rsp_data_q;
      rsp_resp_d  = rsp_resp_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = {cmd_addr[AW-1:2], 2'b00};
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               rsp_write_d = cmd_write;
               if (addr_illegal) begin
                  rsp_valid_d = 1'b1;
                  rsp_resp_d  = 2'b11;
                  rsp_data_d  = '0;
                  state_d     = RESP;
               end else if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WADDR_DATA;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RADDR;
               end
            end
         end
         // AW and W complete independently; move on once both have handshaken.
         WADDR_DATA: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               bready_d = 1'b1;
               state_d  = WRESP;
            end
         end
         WRESP: begin
            if (m_bvalid && bready_q) begin
               bready_d    = 1'b0;
               rsp_resp_d  = m_bresp;
               rsp_data_d  = '0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RADDR: begin
            if (arvalid_q && m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (m_rvalid && rready_q) begin
               rready_d    = 1'b0;
               rsp_data_d  = m_rdata;
               rsp_resp_d  = m_rresp;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_data_q  <= rsp_data_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   // Command payload is only meaningful while a valid qualifies it, so it carries no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_resp  = rsp_resp_q;
   assign m_awaddr  = addr_q;
   assign m_awvalid = awvalid_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_wvalid  = wvalid_q;
   assign m_bready  = bready_q;
   assign m_araddr  = addr_q;
   assign m_arvalid = arvalid_q;
   assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed testbench for axi4lite_cmd_master with a configurable-stall AXI4-Lite register slave.
`timescale 1ns/1ps
module tb_axi4lite_cmd_master;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [31:0]   rsp_data;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic          m_awvalid, m_awready, m_wvalid, m_wready;
   logic [31:0]   m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_bresp, m_rresp;
   logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   axi4lite_cmd_master #(.AW(AW), .ADDR_LIMIT('h20)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_data(rsp_data), .rsp_resp(rsp_resp),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   // Slave model: 8 x 32-bit registers, programmable ready/response stalls.
   int            aw_stall = 0, w_stall = 0, ar_stall = 1, b_stall = 0;
   logic          w_after_aw = 1'b0;
   logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0]   regs [8] = '{default: 32'h0};
   logic          aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
   logic          aw_wait = 1'b0, w_wait = 1'b0, ar_wait = 1'b0;
   int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
   logic [AW-1:0] aw_addr_l = '0, last_awaddr = '0, last_araddr = '0;
   logic [31:0]   w_data_l = '0, r_data_l = '0;
   logic [3:0]    w_strb_l = '0;
   int            aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, arvalid_cyc = 0;
   int            proto_err = 0, valid_extra = 0;

   logic          aw_hs, w_hs, ar_hs;
   logic [AW-1:0] eff_awaddr;
   logic [31:0]   eff_wdata;
   logic [3:0]    eff_wstrb;

   assign m_awready  = m_awvalid && !aw_got && (aw_cnt >= aw_stall);
   assign m_wready   = m_wvalid && !w_got && (w_cnt >= w_stall) && (!w_after_aw || aw_got);
   assign m_bvalid   = b_pend && (b_cnt >= b_stall);
   assign m_bresp    = m_bvalid ? bresp_cfg : 2'b00;
   assign m_arready  = m_arvalid && !r_pend && (ar_cnt >= ar_stall);
   assign m_rvalid   = r_pend;
   assign m_rdata    = r_pend ? r_data_l : 32'h0;
   assign m_rresp    = r_pend ? rresp_cfg : 2'b00;
   assign aw_hs      = m_awvalid && m_awready;
   assign w_hs       = m_wvalid && m_wready;
   assign ar_hs      = m_arvalid && m_arready;
   assign eff_awaddr = aw_got ? aw_addr_l : m_awaddr;
   assign eff_wdata  = w_got ? w_data_l : m_wdata;
   assign eff_wstrb  = w_got ? w_strb_l : m_wstrb;

   always @(posedge clk) begin
      if (!reset_n) begin
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
         aw_wait <= 1'b0; w_wait <= 1'b0; ar_wait <= 1'b0;
      end else begin
         aw_wait <= m_awvalid && !m_awready;
         w_wait  <= m_wvalid && !m_wready;
         ar_wait <= m_arvalid && !m_arready;
         if ((aw_wait && !m_awvalid) || (w_wait && !m_wvalid) || (ar_wait && !m_arvalid))
            proto_err <= proto_err + 1;
         if ((aw_got && m_awvalid) || (w_got && m_wvalid))
            valid_extra <= valid_extra + 1;
         if (m_arvalid) arvalid_cyc <= arvalid_cyc + 1;

         if (aw_hs) begin
            aw_got <= 1'b1; aw_addr_l <= m_awaddr; last_awaddr <= m_awaddr;
            aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1;
         end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
         if (w_hs) begin
            w_got <= 1'b1; w_data_l <= m_wdata; w_strb_l <= m_wstrb;
            w_cnt <= 0; w_hs_n <= w_hs_n + 1;
         end else if (m_wvalid) w_cnt <= w_cnt + 1;

         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            for (int b = 0; b < 4; b++)
               if (eff_wstrb[b]) regs[eff_awaddr[4:2]][8*b +: 8] <= eff_wdata[8*b +: 8];
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
         end else if (b_pend) begin
            if (m_bvalid && m_bready) b_pend <= 1'b0;
            else b_cnt <= b_cnt + 1;
         end

         if (ar_hs) begin
            r_pend <= 1'b1; r_data_l <= regs[m_araddr[4:2]]; last_araddr <= m_araddr;
            ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1;
         end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
         if (r_pend && m_rready) r_pend <= 1'b0;
      end
   end

   // Driver tasks: entered and left #1 after a rising edge.
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit ok);
      ok = 1'b0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      for (int t = 0; t < 50 && !ok; t++) begin
         if (cmd_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int lat);
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      ok = rsp_valid;
   endtask

   task automatic pop_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output bit ok, output int lat);
      bit ok1;
      lat = 0;
      issue(wr, a, d, s, ok1);
      ok = ok1;
      if (ok1) wait_rsp(ok, lat);
   endtask

   task automatic test_reset();
      logic [41:0] outs;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      outs = {cmd_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
              rsp_valid, rsp_write, rsp_data, rsp_resp};
      n_chk++; if (outs !== 42'd0) $display("FAIL reset_outputs: got %h expected 0", outs); else n_pass++;
      reset_n = 1'b1;
      n_chk++; if (cmd_ready !== 1'b0) $display("FAIL reset_release_ready: got %b expected 0", cmd_ready); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_write_read();
      bit ok; int lat; int aw0, w0;
      aw0 = aw_hs_n; w0 = w_hs_n;
      txn(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, ok, lat);
      n_chk++; if (!ok) $display("FAIL wr1_timeout: got no response expected one"); else n_pass++;
      n_chk++; if ({rsp_write, rsp_resp, rsp_data} !== {1'b1, 2'b00, 32'h0})
         $display("FAIL wr1_rsp: got w=%b r=%b d=%h expected w=1 r=00 d=0", rsp_write, rsp_resp, rsp_data); else n_pass++;
      n_chk++; if (lat < 3 || lat > 4) $display("FAIL wr1_latency: got %0d expected 3..4", lat); else n_pass++;
      pop_rsp();
      n_chk++; if ((aw_hs_n - aw0) !== 1 || (w_hs_n - w0) !== 1)
         $display("FAIL wr1_handshakes: got aw=%0d w=%0d expected 1/1", aw_hs_n - aw0, w_hs_n - w0); else n_pass++;
      n_chk++; if (last_awaddr !== 12'h004) $display("FAIL wr1_awaddr: got %h expected 004", last_awaddr); else n_pass++;
      txn(1'b0, 12'h004, 32'h0, 4'h0, ok, lat);
      n_chk++; if ({rsp_write, rsp_resp, rsp_data} !== {1'b0, 2'b00, 32'hDEADBEEF})
         $display("FAIL rd1_rsp: got w=%b r=%b d=%h expected w=0 r=00 d=deadbeef", rsp_write, rsp_resp, rsp_data); else n_pass++;
      n_chk++; if (lat < 3 || lat > 4) $display("FAIL rd1_latency: got %0d expected 3..4", lat); else n_pass++;
      pop_rsp();
      txn(1'b1, 12'h008, 32'h11223344, 4'b0101, ok, lat);
      pop_rsp();
      txn(1'b0, 12'h008, 32'h0, 4'h0, ok, lat);
      n_chk++; if (rsp_data !== 32'h00220044) $display("FAIL rd_strb: got %h expected 00220044", rsp_data); else n_pass++;
      pop_rsp();
      txn(1'b0, 12'h007, 32'h0, 4'h0, ok, lat);
      n_chk++; if (last_araddr !== 12'h004 || rsp_data !== 32'hDEADBEEF)
         $display("FAIL rd_lowbits: got a=%h d=%h expected a=004 d=deadbeef", last_araddr, rsp_data); else n_pass++;
      pop_rsp();
   endtask

   task automatic test_stall();
      bit ok; int lat; int aw0, w0, pe0, ve0;
      aw0 = aw_hs_n; w0 = w_hs_n; pe0 = proto_err; ve0 = valid_extra;
      aw_stall = 5; w_stall = 2; bresp_cfg = 2'b10;
      txn(1'b1, 12'h00C, 32'hCAFE0001, 4'hF, ok, lat);
      n_chk++; if (rsp_resp !== 2'b10) $display("FAIL stall_bresp: got %b expected 10", rsp_resp); else n_pass++;
      n_chk++; if (lat !== 8) $display("FAIL stall_latency: got %0d expected 8", lat); else n_pass++;
      pop_rsp();
      n_chk++; if ((proto_err - pe0) !== 0 || (valid_extra - ve0) !== 0)
         $display("FAIL stall_valids: got drop=%0d extra=%0d expected 0/0", proto_err - pe0, valid_extra - ve0); else n_pass++;
      n_chk++; if ((aw_hs_n - aw0) !== 1 || (w_hs_n - w0) !== 1)
         $display("FAIL stall_handshakes: got aw=%0d w=%0d expected 1/1", aw_hs_n - aw0, w_hs_n - w0); else n_pass++;
      aw_stall = 1; w_stall = 0; bresp_cfg = 2'b00; w_after_aw = 1'b1;
      txn(1'b1, 12'h010, 32'h0BADF00D, 4'hF, ok, lat);
      n_chk++; if (!ok || rsp_resp !== 2'b00) $display("FAIL w_after_aw_rsp: got ok=%b r=%b expected 1/00", ok, rsp_resp); else n_pass++;
      pop_rsp();
      aw_stall = 0; w_after_aw = 1'b0; rresp_cfg = 2'b10;
      txn(1'b0, 12'h010, 32'h0, 4'h0, ok, lat);
      n_chk++; if (rsp_data !== 32'h0BADF00D || rsp_resp !== 2'b10)
         $display("FAIL rresp_pass: got d=%h r=%b expected 0badf00d/10", rsp_data, rsp_resp); else n_pass++;
      pop_rsp();
      rresp_cfg = 2'b00;
      n_chk++; if ((proto_err - pe0) !== 0 || (valid_extra - ve0) !== 0)
         $display("FAIL w_after_aw_valids: got drop=%0d extra=%0d expected 0/0", proto_err - pe0, valid_extra - ve0); else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ok; int lat; int bad; int ar0;
      txn(1'b1, 12'h000, 32'hA5A50F0F, 4'hF, ok, lat);
      pop_rsp();
      txn(1'b0, 12'h000, 32'h0, 4'h0, ok, lat);
      ar0 = ar_hs_n;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A50F0F || rsp_resp !== 2'b00 || cmd_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_chk++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles expected 0", bad); else n_pass++;
      n_chk++; if (ar_hs_n !== ar0) $display("FAIL bp_no_issue: got %0d extra AR expected 0", ar_hs_n - ar0); else n_pass++;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL bp_after_hs: got v=%b rdy=%b expected 0/1", rsp_valid, cmd_ready); else n_pass++;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_chk++; if (cmd_ready !== 1'b0 || m_arvalid !== 1'b1)
         $display("FAIL bp_next_accept: got rdy=%b arv=%b expected 0/1", cmd_ready, m_arvalid); else n_pass++;
      wait_rsp(ok, lat);
      n_chk++; if (!ok || rsp_data !== 32'hDEADBEEF) $display("FAIL bp_next_data: got ok=%b d=%h expected 1/deadbeef", ok, rsp_data); else n_pass++;
      pop_rsp();
   endtask

   task automatic test_reset_mid_wresp();
      bit ok; int lat; int t; logic [41:0] outs;
      b_stall = 20;
      issue(1'b1, 12'h01C, 32'h77665544, 4'hF, ok);
      t = 0;
      while (!m_bready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      n_chk++; if (m_bready !== 1'b1) $display("FAIL rst_reach_wresp: got bready=%b expected 1", m_bready); else n_pass++;
      reset_n = 1'b0;
      @(posedge clk); #1;
      outs = {cmd_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
              rsp_valid, rsp_write, rsp_data, rsp_resp};
      n_chk++; if (outs !== 42'd0) $display("FAIL rst_mid_outputs: got %h expected 0", outs); else n_pass++;
      reset_n = 1'b1;
      b_stall = 0;
      @(posedge clk); #1;
      txn(1'b0, 12'h004, 32'h0, 4'h0, ok, lat);
      n_chk++; if (!ok || rsp_data !== 32'hDEADBEEF || rsp_resp !== 2'b00 || rsp_write !== 1'b0)
         $display("FAIL rst_then_read: got ok=%b d=%h r=%b w=%b expected 1/deadbeef/00/0", ok, rsp_data, rsp_resp, rsp_write); else n_pass++;
      pop_rsp();
   endtask

   task automatic test_back_to_back();
      bit ok; int lat;
      logic [AW-1:0] addrs [4];
      logic [31:0]   datas [4];
      addrs = '{12'h014, 12'h018, 12'h01C, 12'h00C};
      datas = '{32'h01020304, 32'hF0E0D0C0, 32'h13579BDF, 32'h2468ACE0};
      for (int i = 0; i < 4; i++) begin
         txn(1'b1, addrs[i], datas[i], 4'hF, ok, lat);
         pop_rsp();
      end
      for (int i = 0; i < 4; i++) begin
         txn(1'b0, addrs[i], 32'h0, 4'h0, ok, lat);
         n_chk++; if (!ok || rsp_data !== datas[i])
            $display("FAIL b2b_read%0d: got ok=%b d=%h expected 1/%h", i, ok, rsp_data, datas[i]); else n_pass++;
         pop_rsp();
      end
   endtask

   task automatic test_range();
      bit ok; int lat; int ar0, arv0;
      ar0 = ar_hs_n; arv0 = arvalid_cyc;
      txn(1'b0, 12'h020, 32'h0, 4'h0, ok, lat);
`ifdef AXI4LITE_CMD_MASTER_RANGE_CHECK_EN
      n_chk++; if (!ok || rsp_resp !== 2'b11 || rsp_data !== 32'h0)
         $display("FAIL range_reject: got ok=%b r=%b d=%h expected 1/11/0", ok, rsp_resp, rsp_data); else n_pass++;
      n_chk++; if (lat > 2) $display("FAIL range_latency: got %0d expected <=2", lat); else n_pass++;
      n_chk++; if ((arvalid_cyc - arv0) !== 0) $display("FAIL range_no_bus: got %0d arvalid cycles expected 0", arvalid_cyc - arv0); else n_pass++;
`else
      n_chk++; if (!ok || rsp_resp !== 2'b00 || rsp_data !== 32'hA5A50F0F)
         $display("FAIL range_issue: got ok=%b r=%b d=%h expected 1/00/a5a50f0f", ok, rsp_resp, rsp_data); else n_pass++;
      n_chk++; if (last_araddr !== 12'h020 || (ar_hs_n - ar0) !== 1)
         $display("FAIL range_araddr: got a=%h n=%0d expected 020/1", last_araddr, ar_hs_n - ar0); else n_pass++;
`endif
      pop_rsp();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_stall();
      test_backpressure();
      test_reset_mid_wresp();
      test_back_to_back();
      test_range();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
